// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty-cycle capture block.
package pwm_pkg;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} cap_state_t;

  // Two rising edges in one window is already an error, so the count stops there.
  localparam logic [1:0] EDGE_SAT = 2'd2;

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronizer for the asynchronous PWM input plus a registered rising-edge detector.
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pwm_in,
  output logic pin_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   pin_s_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain   <= '0;
      pin_s_d <= 1'b0;
    end else begin
      chain   <= {chain[SYNC_STAGES-2:0], pwm_in};
      pin_s_d <= chain[SYNC_STAGES-1];
    end
  end

  assign pin_s = chain[SYNC_STAGES-1];
  assign rise  = pin_s & ~pin_s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM duty over a 2^WIDTH-clock window aligned to the input rising edge,
// flags static/multi-edge inputs and tracks result stability.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sleep,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty,
  output logic             duty_valid,
  output logic             duty_stable,
  output logic             edge_err,
  output logic             static_lvl
);

  localparam int                SW       = $clog2(STABLE_WINDOWS + 1);
  localparam logic [WIDTH-1:0]  LAST     = '1;
  localparam logic [SW-1:0]     STAB_MAX = SW'(STABLE_WINDOWS);

  cap_state_t       state, state_nx;
  logic             pin_s, rise;
  logic [WIDTH-1:0] arm_cnt, win_cnt;
  logic [WIDTH:0]   hi_cnt, hi_nx;
  logic [1:0]       edge_cnt, edge_nx;
  logic             aligned, misalign, mis_nx;
  logic [SW-1:0]    stab_cnt;
  logic [WIDTH-1:0] duty_nx;
  logic             last, upd, static_nx, err_nx, good;

  pwm_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pwm_in  (pwm_in),
    .pin_s   (pin_s),
    .rise    (rise)
  );

  // Window totals including the current sample's contribution.
  assign hi_nx     = hi_cnt + {{WIDTH{1'b0}}, pin_s};
  assign edge_nx   = (rise && edge_cnt != EDGE_SAT) ? edge_cnt + 2'd1 : edge_cnt;
  assign mis_nx    = misalign | (rise & aligned & (win_cnt != '0));
  assign duty_nx   = hi_nx[WIDTH] ? LAST : hi_nx[WIDTH-1:0];
  assign static_nx = (edge_nx == 2'd0);
  assign err_nx    = (edge_nx >= EDGE_SAT);
  assign good      = !static_nx && !err_nx && (duty_nx == duty);
  assign last      = (state == MEASURE) && (win_cnt == LAST);
  assign upd       = last && !sleep;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!sleep) state_nx = ARM;
      ARM:     if (rise || arm_cnt == LAST) state_nx = MEASURE;
      MEASURE: if (last && (err_nx || mis_nx)) state_nx = ARM;
      default: state_nx = IDLE;
    endcase
    if (sleep) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt    <= '0;
      win_cnt    <= '0;
      hi_cnt     <= '0;
      edge_cnt   <= '0;
      aligned    <= 1'b0;
      misalign   <= 1'b0;
      stab_cnt   <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      edge_err   <= 1'b0;
      static_lvl <= 1'b0;
    end else begin
      duty_valid <= upd;
      if (upd) begin
        duty       <= duty_nx;
        static_lvl <= static_nx;
        edge_err   <= err_nx;
        stab_cnt   <= !good ? '0 : (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + SW'(1);
      end
      if (sleep || state == IDLE) stab_cnt <= '0;

      case (state)
        ARM: begin
          if (rise) begin
            // The aligning edge is sample 0 of the new window.
            win_cnt  <= WIDTH'(1);
            hi_cnt   <= (WIDTH+1)'(1);
            edge_cnt <= 2'd1;
            aligned  <= 1'b1;
            misalign <= 1'b0;
            arm_cnt  <= '0;
          end else if (arm_cnt == LAST) begin
            win_cnt  <= '0;
            hi_cnt   <= '0;
            edge_cnt <= '0;
            aligned  <= 1'b0;
            misalign <= 1'b0;
            arm_cnt  <= '0;
          end else begin
            arm_cnt  <= arm_cnt + WIDTH'(1);
          end
        end
        MEASURE: begin
          if (last) begin
            win_cnt  <= '0;
            hi_cnt   <= '0;
            edge_cnt <= '0;
            misalign <= 1'b0;
            arm_cnt  <= '0;
          end else begin
            win_cnt  <= win_cnt + WIDTH'(1);
            hi_cnt   <= hi_nx;
            edge_cnt <= edge_nx;
            misalign <= mis_nx;
          end
        end
        default: begin
          arm_cnt  <= '0;
          win_cnt  <= '0;
          hi_cnt   <= '0;
          edge_cnt <= '0;
          aligned  <= 1'b0;
          misalign <= 1'b0;
        end
      endcase
    end
  end

  assign duty_stable = (stab_cnt == STAB_MAX);

endmodule
